// File: rtl/pulse_output_gen.sv
// Output stage of the pulse divider: turns each completed count into one pulse
// of programmable width and re-arms the upstream counter.
module pulse_output_gen #(
  parameter int WIDTH_BITS = 16,
  parameter int TOTAL_BITS = 16
) (
  input  logic                  pulse_clock,
  input  logic                  gen_reset,
  input  logic                  gen_enable,
  input  logic                  gen_oneshot,
  input  logic [WIDTH_BITS-1:0] gen_width,
  input  logic                  count_completed,
  output logic                  count_enable_out,
  output logic                  count_reset_out,
  output logic                  pulse_out,
  output logic                  gen_busy,
  output logic [TOTAL_BITS-1:0] pulse_total
);

  typedef enum logic [2:0] {
    IDLE,
    REARM,
    WAIT_CLR,
    ARMED,
    FIRE,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH_BITS-1:0] width_cnt, width_cnt_nxt;
  logic                  fire_start;

  function automatic logic [WIDTH_BITS-1:0] clamp_width(input logic [WIDTH_BITS-1:0] w);
    return (w == '0) ? WIDTH_BITS'(1) : w;
  endfunction

  always_comb begin
    state_nxt     = state;
    width_cnt_nxt = width_cnt;
    fire_start    = 1'b0;
    case (state)
      IDLE: begin
        if (gen_enable) state_nxt = REARM;
      end
      REARM: begin
        state_nxt = gen_enable ? WAIT_CLR : IDLE;
      end
      WAIT_CLR: begin
        // A flag still latched from the previous cycle must clear before arming
        if (!gen_enable)          state_nxt = IDLE;
        else if (!count_completed) state_nxt = ARMED;
      end
      ARMED: begin
        if (!gen_enable) begin
          state_nxt = IDLE;
        end else if (count_completed) begin
          state_nxt     = FIRE;
          width_cnt_nxt = clamp_width(gen_width);
          fire_start    = 1'b1;
        end
      end
      FIRE: begin
        if (!gen_enable) begin
          state_nxt     = IDLE;
          width_cnt_nxt = '0;
        end else if (width_cnt <= WIDTH_BITS'(1)) begin
          state_nxt     = gen_oneshot ? DONE : REARM;
          width_cnt_nxt = '0;
        end else begin
          width_cnt_nxt = width_cnt - WIDTH_BITS'(1);
        end
      end
      DONE: begin
        if (!gen_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop
  always_ff @(posedge pulse_clock or posedge gen_reset) begin
    if (gen_reset) begin
      state            <= IDLE;
      width_cnt        <= '0;
      pulse_total      <= '0;
      pulse_out        <= 1'b0;
      count_enable_out <= 1'b0;
      count_reset_out  <= 1'b0;
      gen_busy         <= 1'b0;
    end else begin
      state            <= state_nxt;
      width_cnt        <= width_cnt_nxt;
      if (fire_start) pulse_total <= pulse_total + TOTAL_BITS'(1);
      pulse_out        <= (state_nxt == FIRE);
      count_enable_out <= (state_nxt == ARMED);
      count_reset_out  <= (state_nxt == REARM);
      gen_busy         <= (state_nxt == REARM) || (state_nxt == WAIT_CLR) ||
                          (state_nxt == ARMED) || (state_nxt == FIRE);
    end
  end

endmodule
